// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss handler: optional dirty-victim write-back, then a line fill
// sourced from a peer cache (snoop hit) or shared memory, returned with its MSI state.
module dcache_miss_ctrl #(
    parameter int ADDR_W  = 11,
    parameter int LINE_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_miss,
    input  logic              write_miss,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic [4:0]        victim_tag,
    input  logic              victim_dirty,
    input  logic [LINE_W-1:0] victim_data,
    output logic              fill_we,
    output logic [LINE_W-1:0] fill_data,
    output logic [1:0]        fill_state,
    output logic              d_rdy,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [1:0]        bus_cmd,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [LINE_W-1:0] bus_wdata,
    input  logic              mem_rdy,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              snoop_search,
    input  logic              snoop_found,
    input  logic [LINE_W-1:0] peer_data,
    output logic              bus_err
);

    localparam int         IDX_W   = ADDR_W - 5;
    localparam logic [7:0] TO_MAX  = 8'(TIMEOUT);
    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_RDX = 2'b10;
    localparam logic [1:0] CMD_WB  = 2'b11;
    localparam logic [1:0] MSI_S   = 2'b01;
    localparam logic [1:0] MSI_M   = 2'b10;

    typedef enum logic [2:0] {
        IDLE, WB_ARB, WB_WAIT, RD_ARB, SNOOP, MEM_WAIT, FILL, DONE
    } state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   addr_q;
    logic [4:0]          vtag_q;
    logic [LINE_W-1:0]   vdata_q;
    logic [LINE_W-1:0]   line_q;
    logic                is_wr_q;
    logic [7:0]          cnt, cnt_n;
    logic                waiting;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_n = state;
        case (state)
            IDLE:     if (read_miss || write_miss) state_n = victim_dirty ? WB_ARB : RD_ARB;
            WB_ARB:   if (bus_gnt)     state_n = WB_WAIT;
            WB_WAIT:  if (mem_rdy)     state_n = RD_ARB;
            RD_ARB:   if (bus_gnt)     state_n = SNOOP;
            SNOOP:    state_n = snoop_found ? FILL : MEM_WAIT;
            MEM_WAIT: if (mem_rdy)     state_n = FILL;
            FILL:     state_n = DONE;
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // The timeout counter only runs while we stay in a wait state; leaving clears it.
    assign waiting = (state == WB_WAIT || state == MEM_WAIT) && (state_n == state);
    assign cnt_n   = (cnt == TO_MAX) ? cnt : cnt + 8'd1;

    // NOTE: the line/address holding registers are reset along with the FSM so a
    // stale victim or fill line can never leak onto the bus after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            vtag_q  <= '0;
            vdata_q <= '0;
            line_q  <= '0;
            is_wr_q <= 1'b0;
            cnt     <= '0;
            bus_err <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples the pre-edge values regardless of statement order.
            state <= state_n;
            if (state == IDLE && (read_miss || write_miss)) begin
                addr_q  <= miss_addr;
                vtag_q  <= victim_tag;
                vdata_q <= victim_data;
                is_wr_q <= write_miss;
            end
            if (state == SNOOP && snoop_found)
                line_q <= peer_data;
            else if (state == MEM_WAIT && mem_rdy)
                line_q <= mem_rdata;
            cnt <= waiting ? cnt_n : '0;
            if (waiting && cnt_n == TO_MAX)
                bus_err <= 1'b1;
        end
    end

    // Outputs decode from the state register and holding registers only; the
    // snoop strobe alone must follow the grant so the peer answers during SNOOP.
    always_comb begin
        fill_we      = 1'b0;
        fill_data    = '0;
        fill_state   = 2'b00;
        d_rdy        = 1'b0;
        bus_req      = 1'b0;
        bus_cmd      = CMD_NOP;
        bus_addr     = '0;
        bus_wdata    = '0;
        snoop_search = 1'b0;
        case (state)
            IDLE, DONE: d_rdy = 1'b1;
            WB_ARB, WB_WAIT: begin
                bus_req   = 1'b1;
                bus_cmd   = CMD_WB;
                bus_addr  = {vtag_q, addr_q[IDX_W-1:0]};
                bus_wdata = vdata_q;
            end
            RD_ARB, SNOOP, MEM_WAIT: begin
                bus_req      = 1'b1;
                bus_cmd      = is_wr_q ? CMD_RDX : CMD_RD;
                bus_addr     = addr_q;
                snoop_search = (state == RD_ARB) && bus_gnt;
            end
            FILL: begin
                fill_we    = 1'b1;
                fill_data  = line_q;
                fill_state = is_wr_q ? MSI_M : MSI_S;
            end
            default: ;
        endcase
    end

`ifndef SYNTHESIS
    // The arbiter must keep the grant for the whole bus transaction.
    gnt_held_a: assert property (@(posedge clk) disable iff (!rst_n)
        (state == WB_WAIT || state == SNOOP || state == MEM_WAIT) |-> bus_gnt);
`endif

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl: a table of miss transactions with
// hand-computed bus/fill expectations, plus reset-abort and timeout sequences.
module tb_dcache_miss_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        read_miss, write_miss;
    logic [10:0] miss_addr;
    logic [4:0]  victim_tag;
    logic        victim_dirty;
    logic [63:0] victim_data;
    logic        fill_we;
    logic [63:0] fill_data;
    logic [1:0]  fill_state;
    logic        d_rdy;
    logic        bus_req, bus_gnt;
    logic [1:0]  bus_cmd;
    logic [10:0] bus_addr;
    logic [63:0] bus_wdata;
    logic        mem_rdy;
    logic [63:0] mem_rdata;
    logic        snoop_search, snoop_found;
    logic [63:0] peer_data;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Arbiter with no competition: grants in the same cycle as the request.
    assign bus_gnt = bus_req;

    dcache_miss_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .read_miss(read_miss), .write_miss(write_miss), .miss_addr(miss_addr),
        .victim_tag(victim_tag), .victim_dirty(victim_dirty), .victim_data(victim_data),
        .fill_we(fill_we), .fill_data(fill_data), .fill_state(fill_state), .d_rdy(d_rdy),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
        .snoop_search(snoop_search), .snoop_found(snoop_found), .peer_data(peer_data),
        .bus_err(bus_err)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [10:0] addr;
        logic [4:0]  vtag;
        logic        dirty;
        logic [63:0] vdata;
        logic        found;
        logic [63:0] peer;
        int          mem_delay;
        logic [63:0] mem_data;
        logic [10:0] exp_wb_addr;
        logic [1:0]  exp_cmd;
        logic [63:0] exp_fill;
        logic [1:0]  exp_state;
        int          exp_done;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        read_miss    = 1'b0;
        write_miss   = 1'b0;
        miss_addr    = '0;
        victim_tag   = '0;
        victim_dirty = 1'b0;
        victim_data  = '0;
        mem_rdy      = 1'b0;
        mem_rdata    = '0;
        snoop_found  = 1'b0;
        peer_data    = '0;
    endtask

    // Plays one miss: acts as memory and peer, counts negedges from the miss until d_rdy.
    task automatic run_vec(input int idx, input vec_t v);
        int wb_cycles = 0;
        int rd_cycles = 0;
        int fills     = 0;
        int done_at   = -1;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        read_miss    = v.rd;
        write_miss   = v.wr;
        miss_addr    = v.addr;
        victim_tag   = v.vtag;
        victim_dirty = v.dirty;
        victim_data  = v.vdata;
        for (int cyc = 1; cyc <= 60 && done_at < 0; cyc++) begin
            @(negedge clk);
            mem_rdy     = 1'b0;
            mem_rdata   = '0;
            snoop_found = 1'b0;
            peer_data   = '0;
            if (cyc == 1) check({tag, " busy d_rdy"}, d_rdy, 0);
            if (fill_we) begin
                fills++;
                check({tag, " fill_data"}, fill_data, v.exp_fill);
                check({tag, " fill_state"}, fill_state, v.exp_state);
                check({tag, " fill bus_req"}, bus_req, 0);
                if (v.found) begin
                    mem_rdy   = 1'b1;
                    mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
                end
            end else if (d_rdy) begin
                done_at = cyc;
                read_miss  = 1'b0;
                write_miss = 1'b0;
            end else if (bus_req && bus_cmd == 2'b11) begin
                wb_cycles++;
                if (wb_cycles == 1) begin
                    check({tag, " wb addr"}, bus_addr, v.exp_wb_addr);
                    check({tag, " wb data"}, bus_wdata, v.vdata);
                end
                if (wb_cycles == 3) mem_rdy = 1'b1;
            end else if (bus_req) begin
                rd_cycles++;
                if (rd_cycles == 1) begin
                    check({tag, " rd cmd"}, bus_cmd, v.exp_cmd);
                    check({tag, " rd addr"}, bus_addr, v.addr);
                    check({tag, " snoop strobe"}, snoop_search, 1);
                end
                if (rd_cycles == 2) begin
                    check({tag, " snoop one cycle"}, snoop_search, 0);
                    snoop_found = v.found;
                    peer_data   = v.peer;
                    if (v.found) begin
                        mem_rdy   = 1'b1;
                        mem_rdata = 64'hBAD1_BAD1_BAD1_BAD1;
                    end
                end
                if (!v.found && rd_cycles == 2 + v.mem_delay) begin
                    mem_rdy   = 1'b1;
                    mem_rdata = v.mem_data;
                end
            end
        end
        check({tag, " d_rdy cycle"}, 64'(done_at), 64'(v.exp_done));
        check({tag, " fill count"}, 64'(fills), 64'd1);
        check({tag, " wb cycles"}, 64'(wb_cycles), v.dirty ? 64'd3 : 64'd0);
        idle_inputs();
    endtask

    initial begin
        // Clean read miss, peer miss, memory answers 10 cycles into MEM_WAIT window.
        vecs[0] = '{1, 0, 11'h245, 5'h00, 0, 64'h0, 0, 64'h0, 10, 64'hDEAD_BEEF_0123_4567,
                    11'h000, 2'b01, 64'hDEAD_BEEF_0123_4567, 2'b01, 14};
        // Dirty write miss: victim {5'h1F, 6'h05} written back first, then BUS_RDX.
        vecs[1] = '{0, 1, 11'h285, 5'h1F, 1, 64'hCAFE_F00D_5555_AAAA, 0, 64'h0, 3,
                    64'h0123_4567_89AB_CDEF, 11'h7C5, 2'b10, 64'h0123_4567_89AB_CDEF, 2'b10, 10};
        // Read miss served by the peer; stray mem_rdy pulses must be ignored.
        vecs[2] = '{1, 0, 11'h0AB, 5'h00, 0, 64'h0, 1, 64'h1111_2222_3333_4444, 0, 64'h0,
                    11'h000, 2'b01, 64'h1111_2222_3333_4444, 2'b01, 4};
        // Both misses together behave as a write.
        vecs[3] = '{1, 1, 11'h123, 5'h00, 0, 64'h0, 0, 64'h0, 2, 64'h5A5A_0F0F_A5A5_F0F0,
                    11'h000, 2'b10, 64'h5A5A_0F0F_A5A5_F0F0, 2'b10, 6};
        // Dirty victim {5'h03, 6'h00}, then read filled by the peer.
        vecs[4] = '{1, 0, 11'h5C0, 5'h03, 1, 64'h0F0F_1E1E_2D2D_3C3C, 1, 64'h7777_8888_9999_0000,
                    0, 64'h0, 11'h0C0, 2'b01, 64'h7777_8888_9999_0000, 2'b01, 7};
        // Write miss at the top address filled by the peer.
        vecs[5] = '{0, 1, 11'h7FF, 5'h00, 0, 64'h0, 1, 64'hFEED_FACE_0BAD_F00D, 0, 64'h0,
                    11'h000, 2'b10, 64'hFEED_FACE_0BAD_F00D, 2'b10, 4};

        idle_inputs();
        rst_n = 1'b0;
        #2;
        check("reset d_rdy", d_rdy, 1);
        check("reset bus_req", bus_req, 0);
        check("reset fill_we", fill_we, 0);
        check("reset bus_cmd", bus_cmd, 0);
        check("reset fill_state", fill_state, 0);
        check("reset bus_err", bus_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Reset asserted while waiting for the write-back to complete.
        @(negedge clk);
        read_miss    = 1'b1;
        miss_addr    = 11'h1C7;
        victim_tag   = 5'h0A;
        victim_dirty = 1'b1;
        victim_data  = 64'h1234_5678_9ABC_DEF0;
        repeat (2) @(negedge clk);
        check("wbwait bus_req", bus_req, 1);
        check("wbwait bus_cmd", bus_cmd, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("abort bus_req", bus_req, 0);
        check("abort d_rdy", d_rdy, 1);
        check("abort fill_we", fill_we, 0);
        check("abort bus_err", bus_err, 0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        // Memory withheld: bus_err rises after 255 cycles in MEM_WAIT and is sticky.
        @(negedge clk);
        read_miss = 1'b1;
        miss_addr = 11'h3A1;
        repeat (3) @(negedge clk);
        check("to bus_req", bus_req, 1);
        check("to err early", bus_err, 0);
        repeat (254) @(negedge clk);
        check("to err at 254", bus_err, 0);
        @(negedge clk);
        check("to err at 255", bus_err, 1);
        repeat (42) @(negedge clk);
        check("to err sticky", bus_err, 1);
        check("to still waiting", bus_req, 1);
        mem_rdy   = 1'b1;
        mem_rdata = 64'hA5A5_5A5A_C3C3_3C3C;
        @(negedge clk);
        mem_rdy   = 1'b0;
        mem_rdata = '0;
        check("late fill_we", fill_we, 1);
        check("late fill_data", fill_data, 64'hA5A5_5A5A_C3C3_3C3C);
        check("late fill_state", fill_state, 2'b01);
        @(negedge clk);
        check("late d_rdy", d_rdy, 1);
        read_miss = 1'b0;
        @(negedge clk);
        check("err after done", bus_err, 1);
        rst_n = 1'b0;
        #1;
        check("err cleared", bus_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
